// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR tap table and PRBS checker state type.
package lfsr_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } prbs_state_t;

  // Bit (t-1) is set for each polynomial term x^t; the shift register's newest bit sits at bit 0.
  function automatic logic [MAX_N-1:0] lfsr_taps(int n);
    logic [MAX_N-1:0] mask;
    case (n)
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/prbs_err_window.sv
// rtl/prbs_err_window.sv - error-monitoring window and loss-of-lock decision while locked.
module prbs_err_window
  import lfsr_pkg::*;
#(
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic err,
  input  logic restart,
  output logic loss
);

  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int ERR_W  = $clog2(LOSS_THR + 1);
  localparam int ERR_W1 = ERR_W + 1;

  logic [WIN_W-1:0]  win;
  logic [ERR_W-1:0]  werr;
  logic [ERR_W1-1:0] werr_inc;

  // The current bit is counted before the threshold test, so loss wins over the window wrap.
  assign werr_inc = {1'b0, werr} + ERR_W1'(err);
  assign loss     = valid && err && (werr_inc >= ERR_W1'(LOSS_THR));

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      win  <= '0;
      werr <= '0;
    end else if (valid) begin
      if (win == WIN_W'(WIN_LEN - 1)) begin
        win  <= '0;
        werr <= '0;
      end else begin
        win  <= win + WIN_W'(1);
        werr <= werr_inc[ERR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising serial PRBS checker with lock tracking and error count.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int N        = 4,
  parameter int SYNC_LEN = 16,
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [MAX_N-1:0] TAPS_FULL = lfsr_taps(N);
  localparam logic [N-1:0]     TAPS      = TAPS_FULL[N-1:0];
  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(SYNC_LEN + 1);

  prbs_state_t        state, state_next;
  logic [N-1:0]       sr, sr_next;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [MATCH_W-1:0] match, match_next;
  logic [CNT_W-1:0]   err_cnt;
  logic               err_q;
  logic               pred, mismatch, lock_err, enter_lock, loss;

  assign pred     = ^(sr & TAPS);
  assign mismatch = data_i ^ pred;
  assign lock_err = valid_i && (state == LOCKED) && mismatch;

  prbs_err_window #(
    .WIN_LEN (WIN_LEN),
    .LOSS_THR(LOSS_THR)
  ) u_win (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .valid  (valid_i && (state == LOCKED)),
    .err    (mismatch),
    .restart(enter_lock),
    .loss   (loss)
  );

  always_comb begin
    state_next = state;
    sr_next    = sr;
    fill_next  = fill;
    match_next = match;
    enter_lock = 1'b0;
    if (valid_i) begin
      case (state)
        FILL: begin
          sr_next = {sr[N-2:0], data_i};
          if (fill == FILL_W'(N - 1)) begin
            state_next = HUNT;
            fill_next  = '0;
            match_next = '0;
          end else begin
            fill_next = fill + FILL_W'(1);
          end
        end
        HUNT: begin
          sr_next = {sr[N-2:0], data_i};
          // An all-zero register predicts zero forever, so it must never build up a match run.
          if ((sr != '0) && !mismatch) begin
            if (match == MATCH_W'(SYNC_LEN - 1)) begin
              state_next = LOCKED;
              match_next = '0;
              enter_lock = 1'b1;
            end else begin
              match_next = match + MATCH_W'(1);
            end
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          if (loss) begin
            state_next = HUNT;
            match_next = '0;
            sr_next    = {sr[N-2:0], data_i};
          end else begin
            sr_next = {sr[N-2:0], pred};
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= FILL;
      sr      <= '0;
      fill    <= '0;
      match   <= '0;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      fill  <= fill_next;
      match <= match_next;
      err_q <= lock_err;
      if (clr_i) begin
        err_cnt <= '0;
      end else if (lock_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign locked_o  = (state == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker against a bit-history reference model.
module tb_prbs_checker;

  localparam int N        = 4;
  localparam int SYNC_LEN = 16;
  localparam int WIN_LEN  = 64;
  localparam int LOSS_THR = 4;
  localparam int CNT_W    = 16;
  localparam int SAT_W    = 3;

  logic clk = 1'b0;
  logic rst_n, data, valid, clr;
  logic locked, err, locked_s, err_s;
  logic [CNT_W-1:0] err_cnt;
  logic [SAT_W-1:0] err_cnt_s;

  always #5 clk = ~clk;

  prbs_checker #(.N(N), .SYNC_LEN(SYNC_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .clr_i(clr),
    .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt));

  prbs_checker #(.N(N), .SYNC_LEN(SYNC_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(SAT_W)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .clr_i(clr),
    .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s));

  // x^4 + x^3 + 1: each bit is the XOR of the bits 4 and 3 positions earlier.
  int tap_d[2] = '{4, 3};

  int n_checks = 0;
  int n_pass   = 0;

  int ghist[$];
  int hist[$];
  int m_mode, m_fill, m_match, m_wpos, m_werr, m_cnt;
  bit m_locked, m_err;

  typedef struct {
    string name;
    int    nbits;
    int    ne;
    int    epos[10];
    int    exp_cnt;
    bit    exp_locked;
    int    exp_pulses;
    int    exp_drops;
    int    exp_relock;
  } scen_t;

  scen_t tab[7];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int next_gen();
    int b = 0;
    foreach (tap_d[i]) b ^= ghist[tap_d[i]-1];
    ghist.push_front(b);
    void'(ghist.pop_back());
    return b;
  endfunction

  task automatic gen_reset();
    ghist = '{1, 0, 0, 0};
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < N; i++) hist.push_back(0);
    m_mode = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0;
    m_locked = 0; m_err = 0;
  endtask

  task automatic shift_in(int b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_step(bit v, bit d, bit c);
    int pred = 0;
    int nz = 0;
    foreach (tap_d[i]) pred ^= hist[tap_d[i]-1];
    foreach (hist[i]) nz |= hist[i];
    m_err = 0;
    if (c) m_cnt = 0;
    if (v) begin
      case (m_mode)
        0: begin
          shift_in(d);
          m_fill++;
          if (m_fill == N) begin m_mode = 1; m_match = 0; end
        end
        1: begin
          if (nz != 0 && int'(d) == pred) m_match++; else m_match = 0;
          shift_in(d);
          if (m_match == SYNC_LEN) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
        end
        default: begin
          if (int'(d) != pred) begin
            m_err = 1;
            if (!c) m_cnt++;
            m_werr++;
          end
          if (m_werr >= LOSS_THR) begin
            m_mode = 1; m_match = 0; shift_in(d);
          end else begin
            shift_in(pred);
            if (m_wpos == WIN_LEN - 1) begin m_wpos = 0; m_werr = 0; end
            else m_wpos++;
          end
        end
      endcase
    end
    m_locked = (m_mode == 2);
  endtask

  function automatic logic [31:0] act_vec();
    return {9'd0, locked, err, err_cnt, locked_s, err_s, err_cnt_s};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [CNT_W-1:0] c16 = (m_cnt > 65535) ? 16'hFFFF : CNT_W'(m_cnt);
    logic [SAT_W-1:0] c3  = (m_cnt > 7) ? 3'd7 : SAT_W'(m_cnt);
    return {9'd0, m_locked, m_err, c16, m_locked, m_err, c3};
  endfunction

  task automatic step(bit v, bit d, bit c);
    valid = v; data = d; clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check("cycle", act_vec(), exp_vec());
  endtask

  task automatic reset_dut(bit v);
    rst_n = 1'b0; valid = v; data = 1'b1; clr = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("reset", act_vec(), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    for (int s = 0; s < 7; s++) begin
      int pulses = 0;
      int drops = 0;
      int lock_at = 0;
      int relock_at = 0;
      bit prev = 0;
      reset_dut(1'b0);
      gen_reset();
      for (int i = 1; i <= tab[s].nbits; i++) begin
        int inv = 0;
        for (int k = 0; k < tab[s].ne; k++) if (tab[s].epos[k] == i) inv = 1;
        step(1'b1, 1'(next_gen() ^ inv), 1'b0);
        if (err) pulses++;
        if (prev && !locked) drops++;
        if (!prev && locked) begin
          if (lock_at == 0) lock_at = i;
          else if (relock_at == 0) relock_at = i;
        end
        prev = locked;
      end
      check($sformatf("%s lock_at", tab[s].name), lock_at, N + SYNC_LEN);
      check($sformatf("%s pulses", tab[s].name), pulses, tab[s].exp_pulses);
      check($sformatf("%s drops", tab[s].name), drops, tab[s].exp_drops);
      check($sformatf("%s relock_at", tab[s].name), relock_at, tab[s].exp_relock);
      check($sformatf("%s err_cnt", tab[s].name), err_cnt, tab[s].exp_cnt);
      check($sformatf("%s locked", tab[s].name), locked, tab[s].exp_locked);
    end
  endtask

  task automatic run_hand();
    int lock_at = 0;
    int vbits = 0;
    int locked_cycles = 0;
    // valid toggling: idle cycles carry random data that must be ignored
    reset_dut(1'b0);
    gen_reset();
    while (vbits < 24) begin
      step(1'b1, 1'(next_gen()), 1'b0);
      vbits++;
      if (locked && lock_at == 0) lock_at = vbits;
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("toggle lock_at", lock_at, N + SYNC_LEN);
    // constant-zero stream
    reset_dut(1'b0);
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) locked_cycles++;
    end
    check("zeros locked_cycles", locked_cycles, 0);
    // clr colliding with an error
    reset_dut(1'b0);
    gen_reset();
    for (int i = 1; i <= 40; i++) step(1'b1, 1'(next_gen() ^ (i == 30 ? 1 : 0)), 1'b0);
    check("clr pre cnt", err_cnt, 1);
    step(1'b1, 1'(next_gen() ^ 1), 1'b1);
    check("clr err_o", err, 1);
    check("clr cnt", err_cnt, 0);
    check("clr locked", locked, 1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'(next_gen()), 1'b0);
    // one reset cycle while locked, stream continues
    reset_dut(1'b1);
    lock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'(next_gen()), 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    check("reset relock_at", lock_at, N + SYNC_LEN);
  endtask

  task automatic run_random();
    reset_dut(1'b0);
    gen_reset();
    for (int i = 0; i < 4000; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit inv = ($urandom_range(0, 99) < 2);
      bit c = ($urandom_range(0, 199) == 0);
      if (i % 1500 == 1499) reset_dut(v);
      else if (v) step(1'b1, 1'(next_gen()) ^ inv, c);
      else step(1'b0, 1'($urandom_range(0, 1)), c);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = 1'b0; clr = 1'b0;
    tab[0] = '{"clean",    1000, 0, '{0,0,0,0,0,0,0,0,0,0},               0, 1'b1, 0, 0, 0};
    tab[1] = '{"single",    300, 1, '{100,0,0,0,0,0,0,0,0,0},             1, 1'b1, 1, 0, 0};
    tab[2] = '{"loss4",     400, 4, '{100,110,120,130,0,0,0,0,0,0},       4, 1'b1, 4, 1, 150};
    tab[3] = '{"three3",    300, 6, '{90,100,110,150,160,170,0,0,0,0},    6, 1'b1, 6, 0, 0};
    tab[4] = '{"straddle",  300, 4, '{146,147,148,149,0,0,0,0,0,0},       4, 1'b1, 4, 0, 0};
    tab[5] = '{"lastbit",   300, 4, '{145,146,147,148,0,0,0,0,0,0},       4, 1'b1, 4, 1, 168};
    tab[6] = '{"nine",      300, 9, '{30,40,50,90,100,110,150,160,170,0}, 9, 1'b1, 9, 0, 0};
    run_table();
    check("sat cnt", err_cnt_s, 7);
    run_hand();
    run_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
